// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory (core C, host H).
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise fixed priority C over H.
`ifndef H
`define H 15
`endif

module dmem_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int WCNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [`H:0] c_addr,
  input  logic [`H:0] c_wd,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [`H:0] c_rd,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [`H:0] h_addr,
  input  logic [`H:0] h_wd,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [`H:0] h_rd,
  output logic        mem_we,
  output logic [`H:0] mem_addr,
  output logic [`H:0] mem_wd,
  input  logic [`H:0] mem_rd
);

  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

  logic [WCNT_W-1:0] c_wait_q, c_wait_d;
  logic [WCNT_W-1:0] h_wait_q, h_wait_d;
  logic              last_h_q, last_h_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic              h_rvalid_q, h_rvalid_d;
  logic [`H:0]       c_rd_q, c_rd_d;
  logic [`H:0]       h_rd_q, h_rd_d;

  logic c_force, h_force, c_win;

  assign c_force = c_req && (c_wait_q == WAIT_MAX);
  assign h_force = h_req && (h_wait_q == WAIT_MAX);

  // A starved port wins outright; two starved ports fall back to "not granted last".
  always_comb begin
    c_win = 1'b0;
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (c_req && h_req) begin
      if (c_force && h_force) begin
        c_win = last_h_q;
      end else if (c_force) begin
        c_win = 1'b1;
      end else if (h_force) begin
        c_win = 1'b0;
      end else begin
`ifdef DMEM_ARB_RR_EN
        c_win = last_h_q;
`else
        c_win = 1'b1;
`endif
      end
      c_gnt = c_win;
      h_gnt = !c_win;
    end else begin
      c_gnt = c_req;
      h_gnt = h_req;
    end
    if (reset) begin
      c_gnt = 1'b0;
      h_gnt = 1'b0;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (c_gnt) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_wd   = c_wd;
    end else if (h_gnt) begin
      mem_we   = h_we;
      mem_addr = h_addr;
      mem_wd   = h_wd;
    end
  end

  always_comb begin
    c_wait_d = c_wait_q;
    h_wait_d = h_wait_q;
    last_h_d = last_h_q;
    if (!c_req || c_gnt) begin
      c_wait_d = '0;
    end else if (c_wait_q < WAIT_MAX) begin
      c_wait_d = c_wait_q + WCNT_W'(1);
    end
    if (!h_req || h_gnt) begin
      h_wait_d = '0;
    end else if (h_wait_q < WAIT_MAX) begin
      h_wait_d = h_wait_q + WCNT_W'(1);
    end
    if (h_gnt) begin
      last_h_d = 1'b1;
    end else if (c_gnt) begin
      last_h_d = 1'b0;
    end
  end

  // Read data is taken straight from memory in the return cycle and held afterwards.
  always_comb begin
    c_rvalid_d = c_gnt && !c_we;
    h_rvalid_d = h_gnt && !h_we;
    c_rd_d     = c_rvalid_q ? mem_rd : c_rd_q;
    h_rd_d     = h_rvalid_q ? mem_rd : h_rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_wait_q   <= '0;
      h_wait_q   <= '0;
      last_h_q   <= 1'b1;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rd_q     <= '0;
      h_rd_q     <= '0;
    end else begin
      c_wait_q   <= c_wait_d;
      h_wait_q   <= h_wait_d;
      last_h_q   <= last_h_d;
      c_rvalid_q <= c_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
      c_rd_q     <= c_rd_d;
      h_rd_q     <= h_rd_d;
    end
  end

  assign c_rvalid = c_rvalid_q && !reset;
  assign h_rvalid = h_rvalid_q && !reset;
  assign c_rd     = reset ? '0 : (c_rvalid_q ? mem_rd : c_rd_q);
  assign h_rd     = reset ? '0 : (h_rvalid_q ? mem_rd : h_rd_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a behavioural single-port memory.
// Expectations cover both the default fixed-priority and DMEM_ARB_RR_EN builds.
`ifndef H
`define H 15
`endif

module tb_dmem_arbiter;

  typedef struct {
    bit          rst;
    bit          cr, cwe;
    logic [15:0] ca, cwd;
    bit          hr, hwe;
    logic [15:0] ha, hwd;
    bit          cg, hg, mwe;
    logic [15:0] ma, mwd;
    bit          cv;
    logic [15:0] crd;
    bit          hv;
    logic [15:0] hrd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        tb_init;
  logic        c_req, c_we, h_req, h_we;
  logic [15:0] c_addr, c_wd, h_addr, h_wd;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid, mem_we;
  logic [15:0] c_rd, h_rd, mem_addr, mem_wd, mem_rd;
  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  dmem_arbiter #(.MAX_WAIT(3), .WCNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rd(c_rd),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wd(h_wd),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rd(h_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Single-port memory: mem[i] = 0x15 + i after init, one-cycle read latency.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i) + 16'h15;
      mem_rd <= '0;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wd;
      mem_rd <= mem[mem_addr[7:0]];
    end
  end

  function automatic vec_t mk(bit rst, bit cr, bit cwe, logic [15:0] ca, logic [15:0] cwd,
                              bit hr, bit hwe, logic [15:0] ha, logic [15:0] hwd,
                              bit cg, bit hg, bit mwe, logic [15:0] ma, logic [15:0] mwd,
                              bit cv, logic [15:0] crd, bit hv, logic [15:0] hrd);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cwe = cwe; v.ca = ca; v.cwd = cwd;
    v.hr = hr; v.hwe = hwe; v.ha = ha; v.hwd = hwd;
    v.cg = cg; v.hg = hg; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
    v.cv = cv; v.crd = crd; v.hv = hv; v.hrd = hrd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset  = v.rst;
    c_req  = v.cr; c_we = v.cwe; c_addr = v.ca; c_wd = v.cwd;
    h_req  = v.hr; h_we = v.hwe; h_addr = v.ha; h_wd = v.hwd;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    checkOutput({p, " c_gnt"},    16'(c_gnt),    16'(v.cg));
    checkOutput({p, " h_gnt"},    16'(h_gnt),    16'(v.hg));
    checkOutput({p, " mem_we"},   16'(mem_we),   16'(v.mwe));
    checkOutput({p, " mem_addr"}, mem_addr,      v.ma);
    checkOutput({p, " mem_wd"},   mem_wd,        v.mwd);
    checkOutput({p, " c_rvalid"}, 16'(c_rvalid), 16'(v.cv));
    checkOutput({p, " c_rd"},     c_rd,          v.crd);
    checkOutput({p, " h_rvalid"}, 16'(h_rvalid), 16'(v.hv));
    checkOutput({p, " h_rd"},     h_rd,          v.hrd);
  endtask

  initial begin
    // reset, single C read, H write/read back-to-back
    vecs.push_back(mk(1, 1,0,5,0,      0,0,0,0,    0,0,0,0,0,      0,0,     0,0));
    vecs.push_back(mk(0, 1,0,5,0,      0,0,0,0,    1,0,0,5,0,      0,0,     0,0));
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      1,'h1A,  0,0));
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,'h1A,  0,0));
    vecs.push_back(mk(0, 0,0,0,0,      1,1,3,7,    0,1,1,3,7,      0,'h1A,  0,0));
    vecs.push_back(mk(0, 0,0,0,0,      1,0,3,0,    0,1,0,3,0,      0,'h1A,  0,0));
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,'h1A,  1,7));
    // continuous contention, C reads 1, H reads 2
`ifdef DMEM_ARB_RR_EN
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,'h1A, 0,7));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,'h16, 0,7));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,'h16, 1,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,'h16, 0,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,'h16, 1,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,'h16, 0,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,'h16, 1,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,'h16, 0,'h17));
`else
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,'h1A, 0,7));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 1,'h16, 0,7));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 1,'h16, 0,7));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,'h16, 0,7));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,'h16, 1,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 1,'h16, 0,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 1,0,0,1,0, 1,'h16, 0,'h17));
    vecs.push_back(mk(0, 1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,'h16, 0,'h17));
`endif
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,'h16,  1,'h17));
    // reset with a read in flight, then first contention goes to C
    vecs.push_back(mk(0, 1,0,5,0,      0,0,0,0,    1,0,0,5,0,      0,'h16,  0,'h17));
    vecs.push_back(mk(1, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,0,     0,0));
    vecs.push_back(mk(0, 1,0,5,0,      1,0,2,0,    1,0,0,5,0,      0,0,     0,0));
    vecs.push_back(mk(0, 0,0,0,0,      1,0,2,0,    0,1,0,2,0,      1,'h1A,  0,0));
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,'h1A,  1,'h17));
    // C write vs H read of the same address
    vecs.push_back(mk(0, 1,1,9,'h55,   1,0,9,0,    1,0,1,9,'h55,   0,'h1A,  0,'h17));
    vecs.push_back(mk(0, 0,0,0,0,      1,0,9,0,    0,1,0,9,0,      0,'h1A,  0,'h17));
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,'h1A,  1,'h55));
    vecs.push_back(mk(0, 1,0,0,0,      0,0,0,0,    1,0,0,0,0,      0,'h1A,  0,'h55));
`ifdef DMEM_ARB_RR_EN
    vecs.push_back(mk(0, 1,1,9,'h66,   1,0,9,0,    0,1,0,9,0,      1,'h15,  0,'h55));
    vecs.push_back(mk(0, 1,1,9,'h66,   0,0,0,0,    1,0,1,9,'h66,   0,'h15,  1,'h55));
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,'h15,  0,'h55));
`else
    vecs.push_back(mk(0, 1,1,9,'h66,   1,0,9,0,    1,0,1,9,'h66,   1,'h15,  0,'h55));
    vecs.push_back(mk(0, 0,0,0,0,      1,0,9,0,    0,1,0,9,0,      0,'h15,  0,'h55));
    vecs.push_back(mk(0, 0,0,0,0,      0,0,0,0,    0,0,0,0,0,      0,'h15,  1,'h66));
`endif

    reset = 1'b1; tb_init = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wd = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wd = 0;
    @(negedge clk);
    tb_init = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVec(i, vecs[i]);
    end

    // lone host streams reads 20..23 back-to-back with no stall
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      reset = 1'b0; c_req = 1'b0;
      h_req = (k < 4); h_we = 1'b0; h_addr = 16'(20 + k); h_wd = '0;
      #1;
      checkOutput($sformatf("burst%0d h_gnt", k), 16'(h_gnt), 16'(k < 4));
      checkOutput($sformatf("burst%0d c_gnt", k), 16'(c_gnt), 16'd0);
      checkOutput($sformatf("burst%0d h_rvalid", k), 16'(h_rvalid), 16'(k > 0));
      checkOutput($sformatf("burst%0d c_rvalid", k), 16'(c_rvalid), 16'd0);
      if (k > 0) checkOutput($sformatf("burst%0d h_rd", k), h_rd, 16'(20 + k - 1) + 16'h15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
